// File: rtl/rc4_crack_controller.sv
// rc4_crack_controller: sits directly downstream of the key generator.
// For each candidate key it launches one RC4 decrypt and checks the plaintext
// bytes as they stream back. A key is dropped at its first illegal byte. On a
// drop the controller pulses the generator's increment input. It latches the
// winning key, or flags failure once the last key in the keyspace is rejected.
//
// Optional feature: define CRACK_KEY_COUNT_EN to add the keys_tested output.
// keys_tested is a saturating count of launched keys.
//
// State     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for start
// LAUNCH    | register current_key into dec_key, pulse dec_start
// CHECK     | judge each streamed plaintext byte
// ADVANCE   | pulse increment; the generator steps on the same edge
// FOUND     | terminal until reset; found_key holds the winner
// NOT_FOUND | terminal until reset; last key rejected, search_fail high
//
// dec_key is loaded on the edge that ends LAUNCH. The core therefore sees
// dec_start one cycle before dec_key holds the new key, and must pick up
// the key on the cycle after dec_start.
module rc4_crack_controller #(
    parameter int          MSG_LEN     = 32,
    parameter logic [7:0]  CHAR_LO     = 8'h61,
    parameter logic [7:0]  CHAR_HI     = 8'h7A,
    parameter int          ALLOW_SPACE = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic [23:0] current_key,
    input  logic        keyspace_exhausted,
    output logic        increment,
    output logic        dec_start,
    output logic [23:0] dec_key,
    output logic        dec_abort,
    input  logic        pt_valid,
    input  logic [7:0]  pt_byte,
    output logic        busy,
    output logic        key_found,
    output logic [23:0] found_key,
`ifdef CRACK_KEY_COUNT_EN
    output logic [23:0] keys_tested,
`endif
    output logic        search_fail
);

    localparam int               CNT_W    = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LAUNCH    = 3'd1,
        CHECK     = 3'd2,
        ADVANCE   = 3'd3,
        FOUND     = 3'd4,
        NOT_FOUND = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic             byte_legal;

    // Judge the byte on the wire this cycle; nothing is buffered.
    always_comb begin
        byte_legal = ((pt_byte >= CHAR_LO) && (pt_byte <= CHAR_HI)) ||
                     ((ALLOW_SPACE != 0) && (pt_byte == 8'h20));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the pulse/status outputs.
    // dec_abort is Mealy on the illegal byte, so the core is killed that same cycle.
    always_comb begin
        state_nxt   = state;
        dec_start   = 1'b0;
        increment   = 1'b0;
        dec_abort   = 1'b0;
        busy        = 1'b0;
        search_fail = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                busy      = 1'b1;
                dec_start = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (pt_valid) begin
                    if (!byte_legal) begin
                        dec_abort = 1'b1;
                        state_nxt = keyspace_exhausted ? NOT_FOUND : ADVANCE;
                    end else if (byte_cnt == LAST_IDX) begin
                        state_nxt = FOUND;
                    end
                end
            end
            ADVANCE: begin
                busy      = 1'b1;
                increment = 1'b1;
                state_nxt = LAUNCH;
            end
            FOUND: begin
                state_nxt = FOUND;
            end
            NOT_FOUND: begin
                search_fail = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Key capture, byte counting and the sticky winning-key latch.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            dec_key   <= 24'h0;
            byte_cnt  <= '0;
            found_key <= 24'h0;
            key_found <= 1'b0;
        end else begin
            if (state == LAUNCH) begin
                dec_key  <= current_key;
                byte_cnt <= '0;
            end
            if (state == CHECK && pt_valid && byte_legal) begin
                if (byte_cnt == LAST_IDX) begin
                    found_key <= dec_key;
                    key_found <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef CRACK_KEY_COUNT_EN
    // Count launched keys. Saturate at all-ones so the counter never wraps.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            keys_tested <= 24'h0;
        end else if (state == LAUNCH && keys_tested != 24'hFFFFFF) begin
            keys_tested <= keys_tested + 24'h1;
        end
    end
`endif

endmodule

// File: tb/tb_rc4_crack_controller.sv
// Testbench for rc4_crack_controller. It uses two instances on shared stimulus:
//   dut_a: default parameters (32-byte message, space allowed)
//   dut_b: one-byte message, space not allowed
// A small key-generator model follows dut_a's increment pulses.
module tb_rc4_crack_controller;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [23:0] current_key;
    logic        keyspace_exhausted;
    logic        pt_valid;
    logic [7:0]  pt_byte;

    logic        increment_a, dec_start_a, dec_abort_a, busy_a, key_found_a, search_fail_a;
    logic [23:0] dec_key_a, found_key_a;
    logic        increment_b, dec_start_b, dec_abort_b, busy_b, key_found_b, search_fail_b;
    logic [23:0] dec_key_b, found_key_b;
`ifdef CRACK_KEY_COUNT_EN
    logic [23:0] keys_tested_a, keys_tested_b;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    logic [23:0] gen_key, gen_base, gen_last;
    int          inc_cnt_a, abort_cnt_a;
    logic        prev_ds, prev_inc, pulse_bad;

    always #5 clk = ~clk;

    rc4_crack_controller dut_a (
        .clk(clk), .nreset(nreset), .start(start), .current_key(current_key),
        .keyspace_exhausted(keyspace_exhausted), .increment(increment_a),
        .dec_start(dec_start_a), .dec_key(dec_key_a), .dec_abort(dec_abort_a),
        .pt_valid(pt_valid), .pt_byte(pt_byte), .busy(busy_a),
        .key_found(key_found_a), .found_key(found_key_a),
`ifdef CRACK_KEY_COUNT_EN
        .keys_tested(keys_tested_a),
`endif
        .search_fail(search_fail_a)
    );

    rc4_crack_controller #(.MSG_LEN(1), .ALLOW_SPACE(0)) dut_b (
        .clk(clk), .nreset(nreset), .start(start), .current_key(current_key),
        .keyspace_exhausted(keyspace_exhausted), .increment(increment_b),
        .dec_start(dec_start_b), .dec_key(dec_key_b), .dec_abort(dec_abort_b),
        .pt_valid(pt_valid), .pt_byte(pt_byte), .busy(busy_b),
        .key_found(key_found_b), .found_key(found_key_b),
`ifdef CRACK_KEY_COUNT_EN
        .keys_tested(keys_tested_b),
`endif
        .search_fail(search_fail_b)
    );

    // Key generator model: reloads gen_base on reset and steps on dut_a's increment.
    always @(posedge clk) begin
        if (!nreset) gen_key <= gen_base;
        else if (increment_a) gen_key <= gen_key + 24'h1;
    end
    assign current_key        = gen_key;
    assign keyspace_exhausted = (gen_key == gen_last);

    // Pulse counters for dut_a.
    always @(posedge clk) begin
        if (!nreset) begin
            inc_cnt_a   <= 0;
            abort_cnt_a <= 0;
        end else begin
            if (increment_a) inc_cnt_a <= inc_cnt_a + 1;
            if (dec_abort_a) abort_cnt_a <= abort_cnt_a + 1;
        end
    end

    // Pulse rules: pulses last at most one cycle, and dec_start never coincides with increment.
    initial pulse_bad = 1'b0;
    always @(negedge clk) begin
        if (nreset) begin
            if ((dec_start_a && increment_a) || (dec_start_a && prev_ds) || (increment_a && prev_inc))
                pulse_bad = 1'b1;
            prev_ds  = dec_start_a;
            prev_inc = increment_a;
        end else begin
            prev_ds  = 1'b0;
            prev_inc = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nreset   = 1'b0;
        start    = 1'b0;
        pt_valid = 1'b0;
        pt_byte  = 8'h00;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    // Pulse start for one cycle. On return, the DUTs are in LAUNCH.
    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one valid byte for one cycle and capture the Mealy abort outputs.
    task automatic send(input logic [7:0] b, output logic oa, output logic ob);
        pt_valid = 1'b1;
        pt_byte  = b;
        #1;
        oa = dec_abort_a;
        ob = dec_abort_b;
        @(posedge clk);
        #1;
        pt_valid = 1'b0;
    endtask

    function automatic logic [7:0] lg(input int i);
        return 8'h61 + 8'(i % 26);
    endfunction

    typedef struct {
        logic [7:0] b;
        logic       leg_a;
        logic       leg_b;
    } vec_t;

    initial begin
        vec_t vecs[11];
        logic oa, ob, any;

        vecs[0]  = '{8'h60, 1'b0, 1'b0};
        vecs[1]  = '{8'h61, 1'b1, 1'b1};
        vecs[2]  = '{8'h7A, 1'b1, 1'b1};
        vecs[3]  = '{8'h7B, 1'b0, 1'b0};
        vecs[4]  = '{8'h20, 1'b1, 1'b0};
        vecs[5]  = '{8'h00, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'h6D, 1'b1, 1'b1};
        vecs[8]  = '{8'h1F, 1'b0, 1'b0};
        vecs[9]  = '{8'h21, 1'b0, 1'b0};
        vecs[10] = '{8'h41, 1'b0, 1'b0};

        gen_base = 24'h0;
        gen_last = 24'hFFFFFF;
        do_reset();

        // Reset state.
        chk("reset_flags", {26'h0, busy_a, key_found_a, search_fail_a, dec_start_a, increment_a, dec_abort_a}, 32'h0);
        chk("reset_dec_key", dec_key_a, 32'h0);
        chk("reset_found_key", found_key_a, 32'h0);
`ifdef CRACK_KEY_COUNT_EN
        chk("reset_keys_tested", keys_tested_a, 32'h0);
`endif
        // A byte presented while IDLE is ignored.
        send(8'hFF, oa, ob);
        chk("idle_pt_ignored", oa, 32'h0);
        chk("idle_busy", busy_a, 32'h0);

        // Byte legality table.
        foreach (vecs[i]) begin
            do_reset();
            go();
            tick();
            send(vecs[i].b, oa, ob);
            chk($sformatf("vec%0d_abort_a", i), oa, {31'h0, ~vecs[i].leg_a});
            chk($sformatf("vec%0d_abort_b", i), ob, {31'h0, ~vecs[i].leg_b});
            chk($sformatf("vec%0d_found_b", i), key_found_b, {31'h0, vecs[i].leg_b});
        end

        // Key 0 decrypts to 32 legal bytes.
        gen_base = 24'h0;
        do_reset();
        go();
        chk("t1_start_to_dec_start", dec_start_a, 32'h1);
        tick();
        any = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send(lg(i), oa, ob);
            any |= oa;
        end
        chk("t1_no_abort", any, 32'h0);
        chk("t1_key_found", key_found_a, 32'h1);
        chk("t1_found_key", found_key_a, 32'h0);
        chk("t1_no_increment", inc_cnt_a, 32'h0);
        chk("t1_busy_low", busy_a, 32'h0);
        send(8'hFF, oa, ob);
        chk("t1_after_found_abort", oa, 32'h0);
        chk("t1_after_found_kf", key_found_a, 32'h1);

        // Keys 0..2 are rejected on the first byte; key 3 is accepted.
        gen_base = 24'h0;
        do_reset();
        go();
        tick();
        for (int k = 0; k < 3; k++) begin
            send(8'h01, oa, ob);
            chk($sformatf("t2_abort_k%0d", k), oa, 32'h1);
            chk($sformatf("t2_increment_k%0d", k), increment_a, 32'h1);
            tick();
            chk($sformatf("t2_dec_start_k%0d", k), dec_start_a, 32'h1);
            tick();
            chk($sformatf("t2_dec_key_k%0d", k), dec_key_a, 32'(k + 1));
        end
        for (int i = 0; i < 32; i++) send(lg(i + 7), oa, ob);
        chk("t2_key_found", key_found_a, 32'h1);
        chk("t2_found_key", found_key_a, 32'h3);
        chk("t2_inc_count", inc_cnt_a, 32'h3);
        chk("t2_abort_count", abort_cnt_a, 32'h3);
`ifdef CRACK_KEY_COUNT_EN
        chk("t2_keys_tested", keys_tested_a, 32'h4);
`endif

        // Key is legal for 31 bytes, then byte 32 is '{'.
        gen_base = 24'h10;
        do_reset();
        go();
        tick();
        for (int i = 0; i < 31; i++) send(lg(i), oa, ob);
        send(8'h7B, oa, ob);
        chk("t3_abort_last", oa, 32'h1);
        chk("t3_increment", increment_a, 32'h1);
        chk("t3_no_found", key_found_a, 32'h0);
        tick();
        tick();
        chk("t3_next_key", dec_key_a, 32'h11);

        // A space is accepted by dut_a and rejected by dut_b.
        gen_base = 24'h0;
        do_reset();
        go();
        tick();
        any = 1'b0;
        for (int i = 0; i < 32; i++) begin
            send(((i % 4) == 0) ? 8'h20 : lg(i), oa, ob);
            any |= oa;
            if (i == 0) chk("t4_space_reject_b", ob, 32'h1);
        end
        chk("t4_space_no_abort_a", any, 32'h0);
        chk("t4_space_found_a", key_found_a, 32'h1);

        // The last key is illegal.
        gen_base = 24'h3FFFFF;
        gen_last = 24'h3FFFFF;
        do_reset();
        go();
        tick();
        chk("t5_dec_key", dec_key_a, 32'h3FFFFF);
        send(8'hFF, oa, ob);
        chk("t5_abort", oa, 32'h1);
        chk("t5_search_fail", search_fail_a, 32'h1);
        chk("t5_no_increment", increment_a, 32'h0);
        chk("t5_busy_low", busy_a, 32'h0);
        go();
        chk("t5_start_ignored", dec_start_a, 32'h0);
        tick();
        chk("t5_fail_sticky", search_fail_a, 32'h1);
        chk("t5_inc_count", inc_cnt_a, 32'h0);
        chk("t5_kf_zero", key_found_a, 32'h0);
`ifdef CRACK_KEY_COUNT_EN
        chk("t5_keys_tested", keys_tested_a, 32'h1);
`endif
        gen_last = 24'hFFFFFF;

        // Reset applied mid-CHECK after 10 bytes.
        gen_base = 24'h00ABCD;
        do_reset();
        go();
        tick();
        chk("t6_dec_key_before", dec_key_a, 32'h00ABCD);
        for (int i = 0; i < 10; i++) send(lg(i), oa, ob);
        nreset = 1'b0;
        tick();
        chk("t6_busy", busy_a, 32'h0);
        chk("t6_key_found", key_found_a, 32'h0);
        chk("t6_dec_key", dec_key_a, 32'h0);
        nreset = 1'b1;
        go();
        chk("t6_relaunch", dec_start_a, 32'h1);
        tick();
        chk("t6_relaunch_key", dec_key_a, 32'h00ABCD);

        chk("pulse_rules", pulse_bad, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rc4_crack_controller.md
Name: rc4_crack_controller

Overview:
- Search sequencer directly downstream of the key generator.
- Takes the current candidate key and launches one RC4 decrypt per key on the decrypt core.
- Checks the streamed plaintext bytes on the fly, aborts a key at the first illegal byte, and pulses the generator's increment input.
- Latches the winning key, or flags failure once the last key in the keyspace is rejected.

Parameters:
- MSG_LEN, 32: plaintext bytes that must all be legal for a key to be accepted (≥1).
- CHAR_LO, 8'h61: lowest legal character ('a').
- CHAR_HI, 8'h7A: highest legal character ('z').
- ALLOW_SPACE, 1: when 1, byte 8'h20 is also legal.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins search; honoured only in IDLE
- current_key  in  24  candidate key from key generator
- keyspace_exhausted  in  1  high when current_key is the last key
- increment  out  1  one-cycle pulse; advances key generator
- dec_start  out  1  one-cycle pulse; launches decrypt core with dec_key
- dec_key  out  24  key presented to decrypt core, registered
- dec_abort  out  1  one-cycle pulse; kills in-flight decrypt
- pt_valid  in  1  plaintext byte valid this cycle
- pt_byte  in  8  plaintext byte
- busy  out  1  high in every state except IDLE, FOUND, NOT_FOUND
- key_found  out  1  sticky; search succeeded
- found_key  out  24  winning key; valid while key_found=1
- search_fail  out  1  sticky; keyspace exhausted with no legal key

Behaviour:
- Reset (nreset=0 at posedge):
  - State goes to IDLE.
  - All outputs 0: increment, dec_start, dec_abort, busy, key_found, search_fail, dec_key=24'h0, found_key=24'h0.
  - byte_cnt=0.
- Reset is honoured mid-search: the FSM returns to IDLE the next cycle. No dec_abort is issued; the decrypt core shares nreset.
- States:
  - IDLE: start=1 -> LAUNCH.
  - LAUNCH (1 cycle): dec_key<=current_key, dec_start=1, byte_cnt<=0 -> CHECK.
  - CHECK: waits for pt_valid. Each valid byte is judged legal if CHAR_LO ≤ pt_byte ≤ CHAR_HI, or if ALLOW_SPACE=1 and pt_byte==8'h20.
    - Illegal byte: dec_abort=1 that cycle. If keyspace_exhausted=1 -> NOT_FOUND, else -> ADVANCE.
    - Legal byte with byte_cnt==MSG_LEN-1: found_key<=dec_key, key_found<=1 -> FOUND.
    - Legal byte otherwise: byte_cnt++.
    - pt_valid=0: hold state.
  - ADVANCE (1 cycle): increment=1 -> LAUNCH. The generator updates on the same edge, so LAUNCH samples the new key.
  - FOUND: terminal until reset; start ignored; pt_valid ignored.
  - NOT_FOUND: search_fail=1; terminal until reset.
- Outputs and timing:
  - increment, dec_start and dec_abort are Moore/Mealy pulses, never high more than 1 cycle each.
  - dec_start and increment are never high in the same cycle.
- Latencies:
  - start -> dec_start: 1 cycle.
  - Illegal byte -> increment: 1 cycle.
  - Illegal byte -> next dec_start: 2 cycles.
- Checking:
  - byte_cnt width is $clog2(MSG_LEN+1).
  - Byte judgement is purely combinational on pt_byte; no buffering.
- Boundary cases:
  - MSG_LEN=1: the first legal byte yields FOUND.
  - Last key is legal: FOUND; search_fail stays 0.
  - Last key is illegal: NOT_FOUND, no increment pulse.
  - pt_valid outside CHECK is ignored.
  - Bytes arriving after FOUND are ignored.

Optional Feature:
- Macro: CRACK_KEY_COUNT_EN.
- When defined, adds output keys_tested [23:0]:
  - Reset 0.
  - Increments by 1 on each LAUNCH cycle, saturating at 24'hFFFFFF.
  - Frozen in FOUND and NOT_FOUND.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start, generator at key 0, core returns "hello..." (32 legal bytes) -> dec_start 1 cycle after start, dec_key=24'h000000, key_found=1, found_key=24'h000000, increment never pulsed.
- Keys 0..2 produce 8'h01 as first byte, key 3 produces 32 legal bytes -> 3 dec_abort pulses, 3 increment pulses each 1 cycle after the abort, found_key=24'h000003, keys_tested=4 when CRACK_KEY_COUNT_EN is defined.
- Key legal for 31 bytes then byte 32 = 8'h7B ('{') -> dec_abort, increment; no key_found.
- ALLOW_SPACE=1, stream contains 8'h20 -> accepted; ALLOW_SPACE=0 with the same stream -> rejected at the space byte.
- keyspace_exhausted=1, current_key=24'h3FFFFF, first byte 8'hFF -> search_fail=1, state NOT_FOUND, no increment; a later start is ignored.
- nreset=0 asserted mid-CHECK after 10 bytes -> next cycle busy=0, key_found=0, dec_key=0; a fresh start relaunches with dec_start.
